// File: rtl/seq_frame_ctrl.sv
// Frame controller: serializes words MSB-first into an overlapping
// 1001 detector and reports a saturating per-frame match count.
module seq_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             bit_out,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             frame_done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} st_t;
  typedef enum logic [1:0] {D0, D1, D10, D100} det_t;

  st_t              st, st_n;
  det_t             det, det_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [IW-1:0]    idx, idx_n;
  logic             last_q, last_n;
  logic             first_q, first_n;
  logic             y_n;
  logic [CNT_W-1:0] cnt_n;
  logic             load;
  logic             b;
  logic             fin;

  always_comb begin
    st_n       = st;
    det_n      = det;
    sr_n       = sr;
    idx_n      = idx;
    last_n     = last_q;
    first_n    = first_q;
    y_n        = 1'b0;
    cnt_n      = match_cnt;
    in_ready   = 1'b0;
    bit_out    = 1'b0;
    frame_done = 1'b0;
    load       = 1'b0;
    b          = sr[WIDTH-1];
    fin        = (idx == '0);

    unique case (st)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      SHIFT: begin
        bit_out  = b;
        in_ready = fin & ~last_q;
        sr_n     = {sr[WIDTH-2:0], 1'b0};
        idx_n    = idx - 1'b1;
        unique case (det)
          D0:   det_n = b ? D1 : D0;
          D1:   det_n = b ? D1 : D10;
          D10:  det_n = b ? D1 : D100;
          D100: begin
            det_n = b ? D1 : D0;
            if (b) begin
              y_n = 1'b1;
              if (match_cnt != CNT_MAX)
                cnt_n = match_cnt + 1'b1;
            end
          end
        endcase
        if (fin) begin
          if (last_q) begin
            st_n    = DONE;
            first_n = 1'b1;
          end else if (in_valid) begin
            load = 1'b1;
          end else begin
            st_n = IDLE;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        st_n       = IDLE;
      end
      default: st_n = IDLE;
    endcase

    // first word of a frame restarts detection and the count
    if (load) begin
      st_n   = SHIFT;
      sr_n   = in_data;
      last_n = in_last;
      idx_n  = IDX_TOP;
      if (first_q) begin
        det_n   = D0;
        cnt_n   = '0;
        first_n = 1'b0;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      st        <= IDLE;
      det       <= D0;
      sr        <= '0;
      idx       <= '0;
      last_q    <= 1'b0;
      first_q   <= 1'b1;
      y         <= 1'b0;
      match_cnt <= '0;
    end else begin
      st        <= st_n;
      det       <= det_n;
      sr        <= sr_n;
      idx       <= idx_n;
      last_q    <= last_n;
      first_q   <= first_n;
      y         <= y_n;
      match_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Bench for seq_frame_ctrl: directed frames then random traffic,
// checked every cycle against a bit-history reference model.
module tb_seq_frame_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;

  logic         in_ready, bit_out, y, frame_done;
  logic [3:0]   cnt4;
  logic         ready_b, bit_b, y_b, done_b;
  logic [1:0]   cnt2;

  seq_frame_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .bit_out(bit_out), .y(y),
    .match_cnt(cnt4), .frame_done(frame_done)
  );

  seq_frame_ctrl #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(ready_b),
    .in_data(in_data), .in_last(in_last),
    .bit_out(bit_b), .y(y_b),
    .match_cnt(cnt2), .frame_done(done_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int yc = 0;

  // reference model: pending bits, recent frame history, match count
  bit pend[$];
  bit hist[$];
  bit pend_last = 1'b0;
  bit done_m = 1'b0;
  bit y_m = 1'b0;
  bit first_m = 1'b1;
  int n_m = 0;

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit m_ready();
    if (done_m) return 1'b0;
    if (pend.size() == 0) return 1'b1;
    return (pend.size() == 1) && !pend_last;
  endfunction

  function automatic bit m_bit();
    return (pend.size() > 0) ? pend[0] : 1'b0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v,
                            input logic [W-1:0] d,
                            input bit l, input bit rdy);
    bit bb;
    if (!rst) begin
      pend.delete();
      hist.delete();
      pend_last = 1'b0;
      done_m = 1'b0;
      y_m = 1'b0;
      first_m = 1'b1;
      n_m = 0;
      return;
    end
    done_m = 1'b0;
    y_m = 1'b0;
    if (pend.size() > 0) begin
      bb = pend.pop_front();
      hist.push_back(bb);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4 && hist[0] && !hist[1]
          && !hist[2] && hist[3]) begin
        y_m = 1'b1;
        n_m++;
      end
      if (pend.size() == 0 && pend_last) begin
        done_m = 1'b1;
        first_m = 1'b1;
      end
    end
    if (v && rdy) begin
      if (first_m) begin
        hist.delete();
        n_m = 0;
        first_m = 1'b0;
      end
      for (int i = W - 1; i >= 0; i--) pend.push_back(d[i]);
      pend_last = l;
    end
  endtask

  task automatic check_outs();
    chk("ready", in_ready, m_ready());
    chk("bit_out", bit_out, m_bit());
    chk("y", y, y_m);
    chk("frame_done", frame_done, done_m);
    chk("match_cnt", cnt4, mn(n_m, 15));
    chk("ready_sat", ready_b, m_ready());
    chk("bit_sat", bit_b, m_bit());
    chk("y_sat", y_b, y_m);
    chk("done_sat", done_b, done_m);
    chk("cnt_sat", cnt2, mn(n_m, 3));
  endtask

  // one clock: model follows the falling edge, outputs checked at rising
  task automatic step();
    bit rdy;
    rdy = m_ready();
    @(negedge clk);
    model_edge(reset, in_valid, in_data, in_last, rdy);
    @(posedge clk);
    check_outs();
    if (y) yc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_data = W'($urandom);
      in_last = 1'($urandom);
      step();
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit l,
                      output int waited);
    bit acc;
    bit rdy;
    acc = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    for (int k = 0; k < 40; k++) begin
      rdy = in_ready;
      step();
      waited++;
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    chk("accept_timeout", acc, 1);
  endtask

  task automatic wait_done(output int waited);
    bit seen;
    seen = 1'b0;
    waited = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      waited++;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_timeout", seen, 1);
  endtask

  int w;
  int dl;

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    @(posedge clk);
    step();
    step();
    chk("rst_ready", in_ready, 1);
    chk("rst_cnt", cnt4, 0);
    chk("rst_bit", bit_out, 0);
    reset = 1'b1;
    idle(2);

    yc = 0;
    send(8'b1001_1001, 1'b1, w);
    wait_done(dl);
    chk("t1_lat", dl, W);
    chk("t1_cnt", cnt4, 2);
    chk("t1_y_at_done", y, 1);
    chk("t1_ycount", yc, 2);
    idle(1);
    chk("t1_cnt_hold", cnt4, 2);
    idle(2);

    yc = 0;
    send(8'b1001_0010, 1'b1, w);
    wait_done(dl);
    chk("ovl_cnt", cnt4, 2);
    chk("ovl_ycount", yc, 2);
    idle(2);

    yc = 0;
    send(8'b0000_0010, 1'b0, w);
    send(8'b0100_0000, 1'b1, w);
    chk("b2b_gap", w, W);
    wait_done(dl);
    chk("xw_cnt", cnt4, 1);
    chk("xw_ycount", yc, 1);
    idle(3);

    yc = 0;
    send(8'b0000_0100, 1'b1, w);
    wait_done(dl);
    chk("fb1_cnt", cnt4, 0);
    send(8'b1000_0000, 1'b1, w);
    wait_done(dl);
    chk("fb2_cnt", cnt4, 0);
    chk("fb_ycount", yc, 0);
    idle(2);

    yc = 0;
    send(8'b1001_1001, 1'b0, w);
    send(8'b1001_1001, 1'b1, w);
    wait_done(dl);
    chk("sat_cnt2", cnt2, 3);
    chk("sat_cnt4", cnt4, 4);
    chk("sat_ycount", yc, 4);
    idle(2);
    chk("sat_hold", cnt2, 3);

    yc = 0;
    send(8'b1001_1001, 1'b1, w);
    in_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mr_ready", in_ready, 1);
    chk("mr_cnt", cnt4, 0);
    chk("mr_done", frame_done, 0);
    idle(12);
    chk("mr_ycount", yc, 0);
    send(8'b0000_1001, 1'b1, w);
    wait_done(dl);
    chk("mr_next_cnt", cnt4, 1);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(99) != 0);
      in_valid = ($urandom_range(3) != 0);
      in_data = W'($urandom);
      in_last = ($urandom_range(2) == 0);
      step();
    end
    reset = 1'b1;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
